// File: rtl/matmul2x2_stream_ctrl.sv
// ---------------------------------------------------------------------------
// matmul2x2_stream_ctrl
//
// Initiator side of the 2x2 matrix-multiply engine's start/done handshake.
// Collects eight operand bytes from a valid/ready stream into held A/B
// registers. It then pulses start for one cycle and waits for the engine's
// done level. After that it captures the four results and streams them out
// over valid/ready, in the order C00, C01, C10, C11.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_data    operand stream in (order a00,a01,a10,a11,b00..b11)
//   in_ready            high only while loading operands
//   a00..a11, b00..b11  held operands to the engine (stable START..next load)
//   start               one-cycle start pulse to the engine
//   done                engine done level (cleared by the engine on start)
//   c0..c3              engine results C00, C01, C10, C11
//   out_valid/out_data  result stream out
//   out_ready           downstream accepts a result
//   busy                low only when idle (loading, no element accepted yet)
//   err                 sticky watchdog abort flag
//
// Optional feature: define MATMUL2X2_STREAM_TIMEOUT_EN to add a watchdog in
// WAIT. If done is not seen within TIMEOUT_CYCLES cycles, the controller
// returns to LOAD without outputting results and sets err until reset.
// Without the macro, WAIT is unbounded and err is tied low.
// ---------------------------------------------------------------------------
module matmul2x2_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 17
`ifdef MATMUL2X2_STREAM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] a00,
  output logic [DATA_W-1:0] a01,
  output logic [DATA_W-1:0] a10,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] b00,
  output logic [DATA_W-1:0] b01,
  output logic [DATA_W-1:0] b10,
  output logic [DATA_W-1:0] b11,
  output logic              start,
  input  logic              done,
  input  logic [RES_W-1:0]  c0,
  input  logic [RES_W-1:0]  c1,
  input  logic [RES_W-1:0]  c2,
  input  logic [RES_W-1:0]  c3,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        idx_reg, idx_next;
  logic [1:0]        ridx_reg, ridx_next;
  logic              load_en;
  logic              capture_en;
  logic              timeout_hit;
  logic [DATA_W-1:0] opnd_reg [8];
  logic [RES_W-1:0]  res_reg [4];
  logic [RES_W-1:0]  c_in [4];

  assign c_in[0] = c0;
  assign c_in[1] = c1;
  assign c_in[2] = c2;
  assign c_in[3] = c3;

  // Operand slot order matches the stream order: A row-major, then B.
  assign a00 = opnd_reg[0];
  assign a01 = opnd_reg[1];
  assign a10 = opnd_reg[2];
  assign a11 = opnd_reg[3];
  assign b00 = opnd_reg[4];
  assign b01 = opnd_reg[5];
  assign b10 = opnd_reg[6];
  assign b11 = opnd_reg[7];

  assign busy     = !(state_reg == LOAD && idx_reg == 3'd0);
  assign out_data = res_reg[ridx_reg];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ridx_next  = ridx_reg;
    load_en    = 1'b0;
    capture_en = 1'b0;
    in_ready   = 1'b0;
    start      = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_en  = 1'b1;
          idx_next = idx_reg + 3'd1;   // wraps to 0 after the 8th element
          if (idx_reg == 3'd7) state_next = START;
        end
      end
      START: begin
        start      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // done is cleared by the engine on the start edge, so any done seen
        // here belongs to the operation just launched.
        if (done) begin
          capture_en = 1'b1;
          ridx_next  = 2'd0;
          state_next = DRAIN;
        end else if (timeout_hit) begin
          state_next = LOAD;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ridx_next = ridx_reg + 2'd1;
          if (ridx_reg == 2'd3) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      idx_reg   <= 3'd0;
      ridx_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ridx_reg  <= ridx_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_opnd
      always_ff @(posedge clk or posedge rst) begin
        if (rst) opnd_reg[gi] <= '0;
        else if (load_en && idx_reg == 3'(gi)) opnd_reg[gi] <= in_data;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_res
      always_ff @(posedge clk or posedge rst) begin
        if (rst) res_reg[gi] <= '0;
        else if (capture_en) res_reg[gi] <= c_in[gi];
      end
    end
  endgenerate

`ifdef MATMUL2X2_STREAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;

  // wait_cnt_reg counts completed WAIT cycles. It is cleared in START, so
  // it starts from zero on every entry to WAIT.
  assign timeout_hit = (state_reg == WAIT) && !done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == START)     wait_cnt_reg <= '0;
      else if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      if (timeout_hit) err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_matmul2x2_stream_ctrl.sv
module tb_matmul2x2_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [7:0]  a00, a01, a10, a11, b00, b01, b10, b11;
  logic        start;
  logic        done;
  logic [16:0] c0, c1, c2, c3;
  logic        out_valid;
  logic [16:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  matmul2x2_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .start(start), .done(done),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- engine stand-in ----------------
  // done clears on the edge that samples start and rises three edges later.
  bit         engine_dead = 1'b0;
  logic [1:0] ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      ecnt <= 2'd0;
    end else if (start) begin
      done <= 1'b0;
      ecnt <= 2'd3;
    end else if (ecnt != 2'd0) begin
      ecnt <= ecnt - 2'd1;
      if (ecnt == 2'd1 && !engine_dead) done <= 1'b1;
    end
  end
  assign c0 = {9'd0, a00} * {9'd0, b00} + {9'd0, a01} * {9'd0, b10};
  assign c1 = {9'd0, a00} * {9'd0, b01} + {9'd0, a01} * {9'd0, b11};
  assign c2 = {9'd0, a10} * {9'd0, b00} + {9'd0, a11} * {9'd0, b10};
  assign c3 = {9'd0, a10} * {9'd0, b01} + {9'd0, a11} * {9'd0, b11};

  // ---------------- behavioural model ----------------
  // Phases: collecting operands / operation in flight / results pending.
  localparam int M_LOAD = 0, M_BUSY = 1, M_OUT = 2;
  int          m_phase = M_LOAD;
  int          m_nacc  = 0;
  int          m_op [8] = '{default: 0};
  bit          m_err = 1'b0;
  int          cyc = 0;
  int          t8 = -100;
  logic [16:0] exp_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_LOAD;
      m_nacc  = 0;
      for (int i = 0; i < 8; i++) m_op[i] = 0;
      m_err = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      case (m_phase)
        M_LOAD: if (in_valid) begin
          m_op[m_nacc] = int'(in_data);
          if (m_nacc == 7) begin
            m_nacc = 0;
            t8 = cyc;
            exp_q.push_back(17'(m_op[0] * m_op[4] + m_op[1] * m_op[6]));
            exp_q.push_back(17'(m_op[0] * m_op[5] + m_op[1] * m_op[7]));
            exp_q.push_back(17'(m_op[2] * m_op[4] + m_op[3] * m_op[6]));
            exp_q.push_back(17'(m_op[2] * m_op[5] + m_op[3] * m_op[7]));
            m_phase = M_BUSY;
          end else begin
            m_nacc++;
          end
        end
        M_BUSY: begin
          // results appear 5 edges after the 8th accept
          if (cyc == t8 + 5 && !engine_dead) m_phase = M_OUT;
`ifdef MATMUL2X2_STREAM_TIMEOUT_EN
          else if (cyc == t8 + 17) begin
            m_phase = M_LOAD;
            m_err = 1'b1;
            exp_q.delete();
          end
`endif
        end
        default: if (out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = M_LOAD;
        end
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [16:0] obs_q [$];
  bit          prev_ov = 1'b0;
  int          rise_delta = -1;
  bit          saw_valid = 1'b0;

  always @(negedge clk) begin
    logic [7:0] ops [8];
    ops = '{a00, a01, a10, a11, b00, b01, b10, b11};
    cmp("in_ready", 32'(in_ready), 32'(m_phase == M_LOAD));
    cmp("busy", 32'(busy), 32'(!(m_phase == M_LOAD && m_nacc == 0)));
    cmp("start", 32'(start), 32'(m_phase == M_BUSY && cyc == t8));
    cmp("out_valid", 32'(out_valid), 32'(m_phase == M_OUT));
    cmp("err", 32'(err), 32'(m_err));
    for (int i = 0; i < 8; i++) cmp("operand", 32'(ops[i]), 32'(m_op[i]));
    if (m_phase == M_OUT && exp_q.size() != 0) cmp("out_data", 32'(out_data), 32'(exp_q[0]));
    if (rst) cmp("out_data_rst", 32'(out_data), 32'd0);
    if (out_valid && !prev_ov) rise_delta = cyc - t8;
    prev_ov = out_valid;
    if (out_valid) saw_valid = 1'b1;
    if (out_valid && out_ready) begin
      obs_q.push_back(out_data);
      $display("result %0d data %0d", obs_q.size() - 1, out_data);
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stall 3 cycles per result
  int stall = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && !out_ready) begin
          stall++;
          if (stall >= 3) out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
          stall = 0;
        end
      end
    endcase
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_op(input logic [7:0] v [8], input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      bit ok;
      int g;
      g = $urandom_range(0, max_gap);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL accept_timeout got in_ready 0 expected 1");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (m_phase == M_LOAD && m_nacc == 0 && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout got busy expected idle");
    end
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] op [8];
    logic [16:0] exp_lit [4];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // basic 1..8, always ready, latency 5
    rdy_mode = 0;
    obs_q.delete();
    op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_op(op, 8, 0);
    wait_idle();
    exp_lit = '{17'd19, 17'd22, 17'd43, 17'd50};
    cmp("lit_count_basic", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) cmp("lit_basic", 32'(obs_q[i]), 32'(exp_lit[i]));
    cmp("lit_latency", 32'(rise_delta), 32'd5);

    // all 255 with 3-cycle stalls per result
    rdy_mode = 2;
    obs_q.delete();
    op = '{default: 8'd255};
    send_op(op, 8, 2);
    wait_idle();
    cmp("lit_count_max", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < obs_q.size(); i++) cmp("lit_max", 32'(obs_q[i]), 32'd130050);

    // back-to-back; second operation sees stale done from the first
    rdy_mode = 0;
    obs_q.delete();
    op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_op(op, 8, 0);
    op = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send_op(op, 8, 0);
    wait_idle();
    exp_lit = '{17'd6, 17'd8, 17'd10, 17'd12};
    cmp("lit_count_b2b", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 4; i++) if (i + 4 < obs_q.size()) cmp("lit_b2b", 32'(obs_q[i + 4]), 32'(exp_lit[i]));

    // reset after the 5th operand, then a fresh operation
    obs_q.delete();
    op = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    send_op(op, 5, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_op(op, 8, 1);
    wait_idle();
    exp_lit = '{17'd19, 17'd22, 17'd43, 17'd50};
    cmp("lit_count_rst", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) cmp("lit_rst", 32'(obs_q[i]), 32'(exp_lit[i]));

    // randomized operations with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) op[i] = 8'($urandom);
      send_op(op, 8, 2);
    end
    wait_idle();

`ifdef MATMUL2X2_STREAM_TIMEOUT_EN
    // engine never answers: watchdog aborts with no results
    rdy_mode = 0;
    engine_dead = 1'b1;
    saw_valid = 1'b0;
    op = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    send_op(op, 8, 0);
    wait_idle();
    cmp("lit_timeout_err", 32'(err), 32'd1);
    cmp("lit_timeout_novalid", 32'(saw_valid), 32'd0);
    cmp("lit_timeout_ready", 32'(in_ready), 32'd1);
    engine_dead = 1'b0;
`else
    cmp("lit_err_tied", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
